// File: rtl/fifo_read_path_pkg.sv
// Shared FIFO constants and the pointer-compare helper, reused by the
// read path here and by the external write-pointer block.
package fifo_read_path_pkg;

  localparam int DEFAULT_SIZE  = 8;
  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  // Pointers carry one wrap bit above the address; ptr_len is the address width.
  function automatic fifo_flags_t ptr_flags(input logic [31:0] rd_ptr,
                                            input logic [31:0] wr_ptr,
                                            input int          ptr_len);
    logic [31:0] diff;
    logic [31:0] addr_mask;
    fifo_flags_t f;
    diff      = rd_ptr ^ wr_ptr;
    addr_mask = (32'd1 << ptr_len) - 32'd1;
    f.empty   = ((diff & ((addr_mask << 1) | 32'd1)) == 32'd0);
    f.full    = ((diff & addr_mask) == 32'd0) && diff[ptr_len[4:0]];
    return f;
  endfunction

endpackage

// File: rtl/fifo_read_path_if.sv
// Read-path bus: write request in, read pointer / data / flags out.
interface fifo_read_path_if
  import fifo_read_path_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PTR_LEN = $clog2(DEFAULT_SIZE)
);
  logic             wr_en;
  logic [PTR_LEN:0] wrt_ptr;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic [PTR_LEN:0] read_ptr;
  logic             full;
  logic             empty;

  modport master (
    output wr_en, wrt_ptr, data_in, rd_en,
    input  data_out, read_ptr, full, empty
  );

  modport slave (
    input  wr_en, wrt_ptr, data_in, rd_en,
    output data_out, read_ptr, full, empty
  );
endinterface

// File: rtl/fifo_flag_gen.sv
// Combinational full/empty from the read and write pointers, zero latency.
module fifo_flag_gen
  import fifo_read_path_pkg::*;
#(
  parameter int PTR_LEN = 3
) (
  input  logic [PTR_LEN:0] rd_ptr,
  input  logic [PTR_LEN:0] wr_ptr,
  output logic             full,
  output logic             empty
);
  fifo_flags_t flags;

  always_comb begin
    flags = ptr_flags(32'(rd_ptr), 32'(wr_ptr), PTR_LEN);
    full  = flags.full;
    empty = flags.empty;
  end
endmodule

// File: rtl/fifo_read_path.sv
// FIFO storage plus read pointer; the write pointer is owned externally
// and only observed here to gate writes and compute the flags.
module fifo_read_path
  import fifo_read_path_pkg::*;
#(
  parameter int SIZE    = DEFAULT_SIZE,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PTR_LEN = $clog2(SIZE)
) (
  input  logic              rclk,
  input  logic              rd_srst,
  fifo_read_path_if.slave   bus
);
  logic [WIDTH-1:0] mem [SIZE];

  logic [PTR_LEN:0] read_ptr_q, read_ptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             full, empty;
  logic             wr_fire, rd_fire;

  fifo_flag_gen #(.PTR_LEN(PTR_LEN)) u_flags (
    .rd_ptr (read_ptr_q),
    .wr_ptr (bus.wrt_ptr),
    .full   (full),
    .empty  (empty)
  );

  // Reset cycles block both ports so nothing lands in storage mid-reset.
  always_comb begin
    wr_fire    = bus.wr_en && !full  && !rd_srst;
    rd_fire    = bus.rd_en && !empty && !rd_srst;
    read_ptr_d = read_ptr_q;
    data_out_d = data_out_q;
    if (rd_fire) begin
      data_out_d = mem[read_ptr_q[PTR_LEN-1:0]];
      read_ptr_d = read_ptr_q + (PTR_LEN+1)'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rd_srst) begin
      read_ptr_q <= '0;
      data_out_q <= '0;
    end else begin
      read_ptr_q <= read_ptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge rclk) begin
    if (wr_fire) mem[bus.wrt_ptr[PTR_LEN-1:0]] <= bus.data_in;
  end

  assign bus.data_out = data_out_q;
  assign bus.read_ptr = read_ptr_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
endmodule

// File: tb/tb_fifo_read_path.sv
// Directed bench for fifo_read_path; the bench plays the write-pointer block.
module tb_fifo_read_path;
  localparam int SIZE    = 8;
  localparam int WIDTH   = 8;
  localparam int PTR_LEN = 3;

  logic rclk = 1'b0;
  logic rd_srst;
  int   n_tests = 0;
  int   n_fail  = 0;

  fifo_read_path_if #(.WIDTH(WIDTH), .PTR_LEN(PTR_LEN)) bus ();

  fifo_read_path #(.SIZE(SIZE), .WIDTH(WIDTH), .PTR_LEN(PTR_LEN)) dut (
    .rclk    (rclk),
    .rd_srst (rd_srst),
    .bus     (bus)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    logic [PTR_LEN:0] w;
    rd_srst     = 1'b1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wrt_ptr = '0;
    bus.data_in = '0;
    tick();
    tick();
    rd_srst = 1'b0;

    // Reads on an empty FIFO are ignored
    bus.rd_en = 1'b1;
    repeat (3) tick();
    chk("rst_read_ptr", 32'(bus.read_ptr), 32'd0);
    chk("rst_empty",    32'(bus.empty),    32'd1);
    chk("rst_full",     32'(bus.full),     32'd0);
    chk("rst_data_out", 32'(bus.data_out), 32'd0);
    bus.rd_en = 1'b0;

    // Fill 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      bus.wrt_ptr = (PTR_LEN+1)'(i);
      bus.data_in = 8'((i + 1) * 8'h11);
      bus.wr_en   = 1'b1;
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.wrt_ptr = 4'd8;
    #1;
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_empty", 32'(bus.empty), 32'd0);
    bus.wr_en   = 1'b1;
    bus.data_in = 8'hFF;
    tick();
    bus.wr_en = 1'b0;

    // Drain; first word proves the 0xFF write was dropped
    bus.rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain_data%0d", i), 32'(bus.data_out), 32'((i + 1) * 8'h11));
      chk($sformatf("drain_ptr%0d", i),  32'(bus.read_ptr), 32'(i + 1));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    tick();
    chk("empty_hold_data", 32'(bus.data_out), 32'h88);
    chk("empty_hold_ptr",  32'(bus.read_ptr), 32'd8);
    bus.rd_en = 1'b0;

    // Wrap: 20 write/read pairs from a fresh pointer pair
    bus.wrt_ptr = '0;
    rd_srst     = 1'b1;
    tick();
    rd_srst = 1'b0;
    w = '0;
    for (int k = 0; k < 20; k++) begin
      bus.wrt_ptr = w;
      bus.data_in = 8'(8'h30 + k);
      bus.wr_en   = 1'b1;
      tick();
      bus.wr_en   = 1'b0;
      w           = w + 4'd1;
      bus.wrt_ptr = w;
      bus.rd_en   = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk($sformatf("wrap_data%0d", k), 32'(bus.data_out), 32'(8'h30 + k));
      chk($sformatf("wrap_empty%0d", k), 32'(bus.empty), 32'd1);
    end
    chk("wrap_read_ptr", 32'(bus.read_ptr), 32'd4);
    bus.wrt_ptr = 4'd12;
    #1;
    chk("wrap_full_msb",  32'(bus.full),  32'd1);
    chk("wrap_empty_msb", 32'(bus.empty), 32'd0);
    bus.wrt_ptr = 4'd4;

    // Preload 4 entries at 4..7, then 6 cycles of simultaneous read+write
    for (int i = 0; i < 4; i++) begin
      bus.wrt_ptr = 4'(4 + i);
      bus.data_in = 8'(8'hA0 + i);
      bus.wr_en   = 1'b1;
      tick();
    end
    bus.wrt_ptr = 4'd8;
    for (int j = 0; j < 6; j++) begin
      bus.data_in = 8'(8'hA4 + j);
      bus.wr_en   = 1'b1;
      bus.rd_en   = 1'b1;
      tick();
      bus.wrt_ptr = bus.wrt_ptr + 4'd1;
      #1;
      chk($sformatf("rw_data%0d", j), 32'(bus.data_out), 32'(8'hA0 + j));
      chk($sformatf("rw_occ%0d", j), 32'(4'(bus.wrt_ptr - bus.read_ptr)), 32'd4);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    // Reset mid-drain; index 6 still holds 0xA2 from the preload
    bus.wrt_ptr = '0;
    rd_srst     = 1'b1;
    tick();
    rd_srst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.wrt_ptr = 4'(i);
      bus.data_in = 8'(8'hC0 + i);
      bus.wr_en   = 1'b1;
      tick();
    end
    bus.wr_en   = 1'b0;
    bus.wrt_ptr = 4'd6;
    bus.rd_en   = 1'b1;
    repeat (3) tick();
    chk("mid_read_ptr", 32'(bus.read_ptr), 32'd3);
    chk("mid_data_out", 32'(bus.data_out), 32'hC2);
    rd_srst     = 1'b1;
    bus.wr_en   = 1'b1;
    bus.data_in = 8'hEE;
    tick();
    chk("srst_read_ptr", 32'(bus.read_ptr), 32'd0);
    chk("srst_data_out", 32'(bus.data_out), 32'd0);
    rd_srst     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wrt_ptr = 4'd7;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("reread%0d", i), 32'(bus.data_out), (i < 6) ? 32'(8'hC0 + i) : 32'hA2);
    end
    chk("reread_empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
